// File: rtl/common.sv
// Shared types for the buffer port arbiter: pixel format, clear colour, arbiter states.
package common;
  localparam int COORD_W = 10;

  typedef logic [23:0] pixel_t;

  localparam pixel_t CLEAR_PIXEL_DEFAULT = 24'h000000;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_t;
endpackage

// File: rtl/clear_scanner.sv
// Raster x/y counter that walks the back buffer during a clear and flags the last pixel.
module clear_scanner
  import common::*;
#(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_restart,
  input  logic               i_en,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_last
);
  logic [COORD_W-1:0] r_x, r_y;
  logic               w_x_end, w_y_end;

  assign w_x_end = (r_x == COORD_W'(H_RES - 1));
  assign w_y_end = (r_y == COORD_W'(V_RES - 1));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_restart) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_en) begin
      if (w_x_end) begin
        r_x <= '0;
        r_y <= w_y_end ? '0 : r_y + COORD_W'(1);
      end else begin
        r_x <= r_x + COORD_W'(1);
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = w_x_end && w_y_end;
endmodule

// File: rtl/buffer_port_arbiter.sv
// Back-buffer port-B arbiter: clear engine, depth-comparator and host read sharing.
// Define BUFFER_CLEAR_EN to build the clear engine; otherwise CLEAR is a one-cycle pass-through.
module buffer_port_arbiter
  import common::*;
#(
  parameter int     H_RES        = 640,
  parameter int     V_RES        = 480,
  parameter int     STARVE_LIMIT = 16,
  parameter pixel_t CLEAR_PIXEL  = CLEAR_PIXEL_DEFAULT
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_switch_buffer,
  output logic               o_clear_done,
  input  logic               i_dc_req,
  input  logic               i_dc_we,
  input  logic [COORD_W-1:0] i_dc_x,
  input  logic [COORD_W-1:0] i_dc_y,
  input  pixel_t             i_dc_wdata,
  output logic               o_dc_grant,
  output pixel_t             o_dc_rdata,
  input  logic               i_host_req,
  input  logic [COORD_W-1:0] i_host_x,
  input  logic [COORD_W-1:0] i_host_y,
  output logic               o_host_ack,
  output pixel_t             o_host_rdata,
  output logic [COORD_W-1:0] o_address_b_x,
  output logic [COORD_W-1:0] o_address_b_y,
  output pixel_t             o_write_data_b,
  output logic               o_write_enable_b,
  input  pixel_t             i_data_b
);
`ifdef BUFFER_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_t         r_state, w_next;
  logic [SW-1:0]      r_starve;
  logic               r_host_ack, r_dc_rd;
  logic [COORD_W-1:0] w_scan_x, w_scan_y;
  logic               w_scan_last, w_scan_en;
  logic               w_run, w_force, w_dc_grant, w_host_grant;

  assign w_scan_en = CLEAR_EN && (r_state == ST_CLEAR);

  clear_scanner #(.H_RES(H_RES), .V_RES(V_RES)) u_scan (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_restart(i_switch_buffer),
    .i_en     (w_scan_en),
    .o_x      (w_scan_x),
    .o_y      (w_scan_y),
    .o_last   (w_scan_last)
  );

  // A buffer swap wins over any request arriving in the same cycle.
  assign w_run        = (r_state == ST_RUN) && !i_switch_buffer;
  assign w_force      = i_host_req && (r_starve == SW'(STARVE_LIMIT));
  assign w_dc_grant   = w_run && i_dc_req && !w_force;
  assign w_host_grant = w_run && i_host_req && (!i_dc_req || w_force);

  always_comb begin
    w_next = r_state;
    if (i_switch_buffer)
      w_next = ST_CLEAR;
    else if ((r_state == ST_CLEAR) && (!CLEAR_EN || w_scan_last))
      w_next = ST_RUN;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= ST_CLEAR;
    else         r_state <= w_next;
  end

  // Starvation counter tracks consecutive denied host cycles, saturating at the limit.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_starve   <= '0;
      r_host_ack <= 1'b0;
      r_dc_rd    <= 1'b0;
    end else begin
      if (w_host_grant || !i_host_req)
        r_starve <= '0;
      else if (r_starve != SW'(STARVE_LIMIT))
        r_starve <= r_starve + SW'(1);
      r_host_ack <= w_host_grant;
      r_dc_rd    <= w_dc_grant && !i_dc_we;
    end
  end

  // Port B is forced idle while reset is asserted so nothing is written mid-reset.
  always_comb begin
    o_address_b_x    = '0;
    o_address_b_y    = '0;
    o_write_data_b   = '0;
    o_write_enable_b = 1'b0;
    if (!i_reset) begin
      if (r_state == ST_CLEAR) begin
        o_address_b_x    = w_scan_x;
        o_address_b_y    = w_scan_y;
        o_write_data_b   = CLEAR_PIXEL;
        o_write_enable_b = CLEAR_EN;
      end else if (w_dc_grant) begin
        o_address_b_x    = i_dc_x;
        o_address_b_y    = i_dc_y;
        o_write_data_b   = i_dc_wdata;
        o_write_enable_b = i_dc_we;
      end else if (w_host_grant) begin
        o_address_b_x    = i_host_x;
        o_address_b_y    = i_host_y;
      end
    end
  end

  assign o_clear_done = (r_state == ST_RUN);
  assign o_dc_grant   = w_dc_grant;
  assign o_host_ack   = r_host_ack;
  assign o_host_rdata = r_host_ack ? i_data_b : '0;
  assign o_dc_rdata   = r_dc_rd    ? i_data_b : '0;
endmodule

// File: tb/tb_buffer_port_arbiter.sv
// Directed bench for buffer_port_arbiter with a small port-B memory model (4x2 back buffer).
module tb_buffer_port_arbiter;
  import common::*;

  localparam pixel_t CP = 24'h5A5A5A;

  logic         clk = 1'b0, rst = 1'b1;
  logic         sw, clear_done;
  logic         dc_req, dc_we, dc_grant;
  logic [9:0]   dc_x, dc_y;
  pixel_t       dc_wd, dc_rdata;
  logic         host_req, host_ack;
  logic [9:0]   hx, hy;
  pixel_t       host_rdata;
  logic [9:0]   ax, ay;
  pixel_t       wd, data_b;
  logic         we;
  int           n_chk = 0, n_fail = 0;
  pixel_t       mem [0:1023];

  always #5 clk = ~clk;

  buffer_port_arbiter #(.H_RES(4), .V_RES(2), .STARVE_LIMIT(16), .CLEAR_PIXEL(CP)) dut (
    .i_clock(clk), .i_reset(rst), .i_switch_buffer(sw), .o_clear_done(clear_done),
    .i_dc_req(dc_req), .i_dc_we(dc_we), .i_dc_x(dc_x), .i_dc_y(dc_y), .i_dc_wdata(dc_wd),
    .o_dc_grant(dc_grant), .o_dc_rdata(dc_rdata),
    .i_host_req(host_req), .i_host_x(hx), .i_host_y(hy), .o_host_ack(host_ack),
    .o_host_rdata(host_rdata),
    .o_address_b_x(ax), .o_address_b_y(ay), .o_write_data_b(wd), .o_write_enable_b(we),
    .i_data_b(data_b)
  );

  function automatic int idx(input logic [9:0] x, input logic [9:0] y);
    return int'({y[4:0], x[4:0]});
  endfunction

  always @(posedge clk) begin
    data_b <= mem[idx(ax, ay)];
    if (we) mem[idx(ax, ay)] <= wd;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic wait_run();
    int n = 0;
    while (clear_done !== 1'b1 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    chk("wait_run", clear_done, 1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    sw = 0; dc_we = 0; dc_x = 0; dc_y = 0; dc_wd = 0; hx = 0; hy = 0;
    dc_req = 1; host_req = 1;
    #12;
    chk("rst_done", clear_done, 0);
    chk("rst_dgnt", dc_grant, 0);
    chk("rst_ack", host_ack, 0);
    chk("rst_we", we, 0);

    @(negedge clk); rst = 0; host_req = 0; #1;
`ifdef BUFFER_CLEAR_EN
    for (int i = 0; i < 8; i++) begin
      chk("clr_we", we, 1);
      chk("clr_x", ax, i % 4);
      chk("clr_y", ay, i / 4);
      chk("clr_wd", wd, CP);
      chk("clr_gnt", dc_grant, 0);
      chk("clr_done", clear_done, 0);
      @(negedge clk); #1;
    end
`else
    chk("noclr_we", we, 0);
    chk("noclr_done", clear_done, 0);
    chk("noclr_gnt", dc_grant, 0);
    @(negedge clk); #1;
`endif
    chk("run_done", clear_done, 1);
    chk("run_gnt", dc_grant, 1);

    // depth-comparator writes
    @(negedge clk); dc_we = 1; dc_x = 5; dc_y = 7; dc_wd = 24'hABCDEF; #1;
    chk("dcw_gnt", dc_grant, 1);
    chk("dcw_we", we, 1);
    chk("dcw_x", ax, 5);
    chk("dcw_y", ay, 7);
    chk("dcw_wd", wd, 24'hABCDEF);
    @(negedge clk); dc_x = 2; dc_y = 3; dc_wd = 24'h123456; #1;
    chk("dcw2_x", ax, 2);

    // host reads
    @(negedge clk); dc_req = 0; dc_we = 0; host_req = 1; hx = 2; hy = 3; #1;
    chk("hr_dgnt", dc_grant, 0);
    chk("hr_we", we, 0);
    chk("hr_x", ax, 2);
    chk("hr_y", ay, 3);
    @(negedge clk); host_req = 0; #1;
    chk("hr_ack", host_ack, 1);
    chk("hr_data", host_rdata, 24'h123456);
    @(negedge clk); host_req = 1; hx = 1; hy = 1; #1;
    chk("hr_ack_low", host_ack, 0);
    @(negedge clk); host_req = 0; #1;
`ifdef BUFFER_CLEAR_EN
    chk("hr_clrpix", host_rdata, CP);
`else
    chk("hr_noclrpix", host_rdata, 0);
`endif

    // depth-comparator read
    @(negedge clk); dc_req = 1; dc_x = 5; dc_y = 7; #1;
    @(negedge clk); dc_req = 0; #1;
    chk("dcr_data", dc_rdata, 24'hABCDEF);

    // starvation: host forced on the 17th requesting cycle
    @(negedge clk); dc_req = 1; dc_we = 0; dc_x = 1; dc_y = 0; host_req = 1; hx = 5; hy = 7;
    for (int k = 0; k < 18; k++) begin
      #1;
      chk("stv_dgnt", dc_grant, k != 16);
      chk("stv_ack", host_ack, k == 17);
      if (k == 16) chk("stv_x", ax, 5);
      if (k == 17) chk("stv_data", host_rdata, 24'hABCDEF);
      @(negedge clk);
    end
    host_req = 0;

    // buffer swap with a coincident dc write
    dc_req = 1; dc_we = 1; dc_x = 3; dc_y = 0; dc_wd = 24'hFFFFFF; sw = 1; #1;
    chk("sw_gnt", dc_grant, 0);
    chk("sw_we", we, 0);
    @(negedge clk); sw = 0; #1;
    chk("sw_done", clear_done, 0);
    chk("sw_gnt2", dc_grant, 0);
`ifdef BUFFER_CLEAR_EN
    chk("sw_we2", we, 1);
    chk("sw_x", ax, 0);
    chk("sw_y", ay, 0);
    for (int i = 1; i < 7; i++) begin
      @(negedge clk); #1;
    end
    chk("mid_x", ax, 2);
    chk("mid_y", ay, 1);
`else
    chk("sw_we2", we, 0);
    @(negedge clk); #1;
    chk("sw_done2", clear_done, 1);
`endif
    rst = 1; #1;
    chk("mrst_done", clear_done, 0);
    chk("mrst_we", we, 0);
    chk("mrst_x", ax, 0);
    chk("mrst_wd", wd, 0);
    chk("mrst_gnt", dc_grant, 0);
    @(negedge clk); rst = 0; #1;
`ifdef BUFFER_CLEAR_EN
    chk("rest_we", we, 1);
    chk("rest_x", ax, 0);
    chk("rest_y", ay, 0);
`else
    chk("rest_we", we, 0);
`endif
    wait_run();

    // reset while a host ack is outstanding
    @(negedge clk); dc_req = 0; dc_we = 0; host_req = 1; hx = 2; hy = 3;
    @(posedge clk); #2;
    chk("rd_ack", host_ack, 1);
    rst = 1; #1;
    chk("rd_rst_ack", host_ack, 0);
    chk("rd_rst_data", host_rdata, 0);
    @(negedge clk); rst = 0; host_req = 0; #1;
    wait_run();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/buffer_port_arbiter.md
BUFFER_PORT_ARBITER -- requirements
Module: buffer_port_arbiter

Interface
REQ-001 SHALL have parameter H_RES, default 640, meaning the horizontal pixel count of the back buffer.
REQ-002 SHALL have parameter V_RES, default 480, meaning the vertical pixel count of the back buffer.
REQ-003 SHALL have parameter STARVE_LIMIT, default 16, meaning the number of denied cycles after which a host read is forced through.
REQ-004 SHALL have parameter CLEAR_PIXEL, pixel_t, default package constant, meaning the value written to every location during a clear.
REQ-005 SHALL have ports: clock in 1 system clock; reset in 1 asynchronous active-high reset.
REQ-006 SHALL have ports: switch_buffer in 1 one-cycle pulse, back buffer swapped; clear_done out 1 level, back buffer cleared and open for drawing.
REQ-007 SHALL have depth-comparator ports: dc_req in 1; dc_we in 1; dc_x in 10; dc_y in 10; dc_wdata in pixel_t; dc_grant out 1; dc_rdata out pixel_t.
REQ-008 SHALL have host read ports: host_req in 1; host_x in 10; host_y in 10; host_ack out 1; host_rdata out pixel_t.
REQ-009 SHALL have buffer port-B ports: address_b_x out 10; address_b_y out 10; write_data_b out pixel_t; write_enable_b out 1; data_b in pixel_t, valid one cycle after address.

Function
REQ-010 SHALL implement states CLEAR and RUN; reset enters CLEAR with counters at (0,0).
REQ-011 In CLEAR SHALL write CLEAR_PIXEL to (cx,cy) every cycle, cx incrementing 0..H_RES-1, then wrapping to 0 and incrementing cy.
REQ-012 SHALL leave CLEAR for RUN the cycle after writing (H_RES-1,V_RES-1), asserting clear_done from that cycle (H_RES*V_RES writes total).
REQ-013 SHALL, on switch_buffer in any state, deassert clear_done next cycle, enter CLEAR and restart counters at (0,0).
REQ-014 In CLEAR SHALL hold dc_grant and host_ack low; requesters hold requests.
REQ-015 In RUN SHALL drive dc_grant combinationally high when dc_req is high and the host is not being forced.
REQ-016 SHALL drive port B from dc signals on a dc grant cycle; write_enable_b = dc_we.
REQ-017 SHALL present dc_rdata = data_b one cycle after a dc grant with dc_we low.
REQ-018 SHALL grant host when host_req is high and dc_req is low, or when the starvation counter equals STARVE_LIMIT.
REQ-019 SHALL increment the starvation counter each cycle host_req is high and denied, clear it on host grant or when host_req drops; saturates at STARVE_LIMIT.
REQ-020 SHALL pulse host_ack one cycle after a host grant, with host_rdata = data_b in that cycle; host reads never write.
REQ-021 SHALL hold write_enable_b low on any cycle with no grant and outside CLEAR.
REQ-022 SHALL give switch_buffer priority over a coincident grant: no grant is issued in that cycle.
REQ-023 SHALL never issue dc_grant and a host grant in the same cycle.

Reset
REQ-024 Asynchronous reset SHALL set: clear_done 0, dc_grant 0, host_ack 0, write_enable_b 0, counters 0, starvation 0, state CLEAR.
REQ-025 Reset mid-clear or mid-read SHALL discard the pending host_ack and restart the clear from (0,0).

Configuration
REQ-026 With BUFFER_CLEAR_EN defined SHALL include the clear engine per REQ-010..013.
REQ-027 Without BUFFER_CLEAR_EN SHALL skip CLEAR: after reset or switch_buffer, enter RUN and assert clear_done one cycle later, never writing CLEAR_PIXEL.

Structure
REQ-028 pixel_t, CLEAR_PIXEL default and the arbiter state enum SHALL live in package common.
REQ-029 A sub-module clear_scanner (x/y counter with last-pixel flag) SHALL be used; arbitration stays in the top module.

Verification
REQ-030 Reset released, H_RES=4, V_RES=2 -> 8 writes of CLEAR_PIXEL, (0,0)..(3,1) in order; clear_done high in cycle 9.
REQ-031 RUN, dc_req with dc_we=1 at (5,7), data 0xABCDEF -> dc_grant same cycle, write_enable_b=1, address (5,7).
REQ-032 RUN, host_req at (2,3), dc idle -> host_ack one cycle later, host_rdata equals stored pixel.
REQ-033 dc_req held high continuously, host_req high -> host granted on denied cycle 16, dc_grant low that cycle.
REQ-034 switch_buffer pulse mid-RUN with dc_req high -> no grant that cycle, clear_done low next cycle, clear restarts at (0,0).
REQ-035 Reset asserted mid-clear at (2,1) -> all outputs zero immediately; clear restarts at (0,0) after release.
